// File: rtl/axi_block_bridge.sv
// axi_block_bridge: turns cache refill / write-back block requests into AXI4 INCR bursts.
// Optional feature macro AXI_RESP_CHECK_EN: sticky o_bus_error on any non-OKAY RRESP/BRESP.
module axi_block_bridge #(
  parameter int ADDR_WIDTH     = 64,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int BLOCK_WIDTH    = 512
) (
  input  logic                        clk,
  input  logic                        arstn,
  input  logic                        i_start_read,
  input  logic                        i_start_write,
  input  logic [ADDR_WIDTH-1:0]       i_addr,
  input  logic [BLOCK_WIDTH-1:0]      i_data_block,
  output logic [BLOCK_WIDTH-1:0]      o_data_block,
  output logic                        o_read_last,
  output logic                        o_b_resp,
  output logic                        o_bus_error,
  output logic [ADDR_WIDTH-1:0]       m_araddr,
  output logic [7:0]                  m_arlen,
  output logic [2:0]                  m_arsize,
  output logic [1:0]                  m_arburst,
  output logic                        m_arvalid,
  input  logic                        m_arready,
  input  logic [AXI_DATA_WIDTH-1:0]   m_rdata,
  input  logic [1:0]                  m_rresp,
  input  logic                        m_rlast,
  input  logic                        m_rvalid,
  output logic                        m_rready,
  output logic [ADDR_WIDTH-1:0]       m_awaddr,
  output logic [7:0]                  m_awlen,
  output logic [2:0]                  m_awsize,
  output logic [1:0]                  m_awburst,
  output logic                        m_awvalid,
  input  logic                        m_awready,
  output logic [AXI_DATA_WIDTH-1:0]   m_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] m_wstrb,
  output logic                        m_wlast,
  output logic                        m_wvalid,
  input  logic                        m_wready,
  input  logic [1:0]                  m_bresp,
  input  logic                        m_bvalid,
  output logic                        m_bready
);
  localparam int BEATS = BLOCK_WIDTH / AXI_DATA_WIDTH;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFF_W = $clog2(BLOCK_WIDTH / 8);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [7:0]       AX_LEN    = 8'(BEATS - 1);
  localparam logic [2:0]       AX_SIZE   = 3'($clog2(AXI_DATA_WIDTH / 8));

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW, S_W, S_B, S_DONE} state_e;

  state_e                                    state_q, state_d;
  logic [ADDR_WIDTH-1:0]                     addr_q;
  logic [BLOCK_WIDTH-1:0]                    wbuf_q;
  logic [BEATS-1:0][AXI_DATA_WIDTH-1:0]      rblk_q;
  logic [CNT_W-1:0]                          cnt_q;
  logic                                      is_wr_q;
  logic                                      accept, r_hs, w_hs;

  assign accept = (state_q == S_IDLE) && (i_start_write || i_start_read);
  assign r_hs   = m_rvalid && m_rready;
  assign w_hs   = m_wvalid && m_wready;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // The beat counter alone ends a read burst; RLAST is deliberately not consulted.
  always_comb begin
    state_d     = state_q;
    m_arvalid   = 1'b0;
    m_rready    = 1'b0;
    m_awvalid   = 1'b0;
    m_wvalid    = 1'b0;
    m_bready    = 1'b0;
    o_read_last = 1'b0;
    o_b_resp    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (i_start_write)     state_d = S_AW;
        else if (i_start_read) state_d = S_AR;
      end
      S_AR: begin
        m_arvalid = 1'b1;
        if (m_arready) state_d = S_R;
      end
      S_R: begin
        m_rready = 1'b1;
        if (m_rvalid && cnt_q == LAST_BEAT) state_d = S_DONE;
      end
      S_AW: begin
        m_awvalid = 1'b1;
        if (m_awready) state_d = S_W;
      end
      S_W: begin
        m_wvalid = 1'b1;
        if (m_wready && cnt_q == LAST_BEAT) state_d = S_B;
      end
      S_B: begin
        m_bready = 1'b1;
        if (m_bvalid) state_d = S_DONE;
      end
      S_DONE: begin
        o_read_last = !is_wr_q;
        o_b_resp    = is_wr_q;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      addr_q  <= '0;
      wbuf_q  <= '0;
      cnt_q   <= '0;
      is_wr_q <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= {i_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
        is_wr_q <= i_start_write;
        cnt_q   <= '0;
        if (i_start_write) wbuf_q <= i_data_block;
      end
      if (r_hs || w_hs) cnt_q <= cnt_q + CNT_W'(1);
      if (w_hs) wbuf_q <= wbuf_q >> AXI_DATA_WIDTH;
    end
  end

  // Refill words land in place; untouched words keep the previous block until overwritten.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn)    rblk_q        <= '0;
    else if (r_hs) rblk_q[cnt_q] <= m_rdata;
  end

  assign o_data_block = rblk_q;

  assign m_araddr  = addr_q;
  assign m_arlen   = AX_LEN;
  assign m_arsize  = AX_SIZE;
  assign m_arburst = 2'b01;
  assign m_awaddr  = addr_q;
  assign m_awlen   = AX_LEN;
  assign m_awsize  = AX_SIZE;
  assign m_awburst = 2'b01;
  assign m_wdata   = wbuf_q[AXI_DATA_WIDTH-1:0];
  assign m_wstrb   = '1;
  assign m_wlast   = (state_q == S_W) && (cnt_q == LAST_BEAT);

`ifdef AXI_RESP_CHECK_EN
  logic err_q;
  logic b_hs;
  assign b_hs = m_bvalid && m_bready;
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) err_q <= 1'b0;
    else if ((r_hs && m_rresp != 2'b00) || (b_hs && m_bresp != 2'b00)) err_q <= 1'b1;
  end
  assign o_bus_error = err_q;
`else
  assign o_bus_error = 1'b0;
`endif

  logic unused_in;
  assign unused_in = &{1'b0, m_rlast, i_addr[OFF_W-1:0], m_rresp, m_bresp};

endmodule

// File: tb/tb_axi_block_bridge.sv
// Bench for axi_block_bridge: AXI slave model, per-cycle handshake-level checker, directed tests.
module tb_axi_block_bridge;
  localparam int AW = 64, DW = 64, BW = 512, BEATS = 8;

  logic clk = 1'b0, arstn = 1'b0;
  logic i_start_read = 1'b0, i_start_write = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [BW-1:0] i_data_block = '0, o_data_block;
  logic o_read_last, o_b_resp, o_bus_error;
  logic [AW-1:0] m_araddr, m_awaddr;
  logic [7:0] m_arlen, m_awlen;
  logic [2:0] m_arsize, m_awsize;
  logic [1:0] m_arburst, m_awburst;
  logic m_arvalid, m_arready = 1'b0;
  logic [DW-1:0] m_rdata = '0;
  logic [1:0] m_rresp = 2'b00;
  logic m_rlast = 1'b0, m_rvalid = 1'b0, m_rready;
  logic m_awvalid, m_awready = 1'b0;
  logic [DW-1:0] m_wdata;
  logic [DW/8-1:0] m_wstrb;
  logic m_wlast, m_wvalid, m_wready = 1'b0;
  logic [1:0] m_bresp = 2'b00;
  logic m_bvalid = 1'b0, m_bready;

  int checks = 0, failures = 0;

  axi_block_bridge dut (
    .clk(clk), .arstn(arstn), .i_start_read(i_start_read), .i_start_write(i_start_write),
    .i_addr(i_addr), .i_data_block(i_data_block), .o_data_block(o_data_block),
    .o_read_last(o_read_last), .o_b_resp(o_b_resp), .o_bus_error(o_bus_error),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // slave configuration, set by the directed tests
  int ar_delay = 0;
  int rlast_at = 7;
  bit r_gap = 1'b0;
  bit w_tog = 1'b0;
  logic [DW-1:0] rd_base = '0;
  logic [1:0] bresp_cfg = 2'b00;

  // AXI slave: handshakes seen at the negedge take effect on the following posedge
  initial begin : slave
    bit ar_hs, r_hs, wl_hs, b_hs, r_act, tog;
    int ar_cnt, r_beat, sc;
    r_act = 1'b0; tog = 1'b0; ar_cnt = 0; r_beat = 0; sc = 0;
    forever begin
      @(negedge clk);
      ar_hs = m_arvalid && m_arready;
      r_hs  = m_rvalid && m_rready;
      wl_hs = m_wvalid && m_wready && m_wlast;
      b_hs  = m_bvalid && m_bready;
      @(posedge clk);
      #1;
      sc++;
      if (!arstn) begin
        m_arready = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0; m_awready = 1'b0;
        m_wready = 1'b0; m_bvalid = 1'b0; r_act = 1'b0; ar_cnt = 0; r_beat = 0;
      end else begin
        if (ar_hs) begin r_act = 1'b1; r_beat = 0; end
        if (r_hs) r_beat++;
        if (r_beat >= BEATS) r_act = 1'b0;
        if (m_arvalid) begin m_arready = (ar_cnt >= ar_delay); ar_cnt++; end
        else begin m_arready = 1'b0; ar_cnt = 0; end
        m_rvalid = r_act && !(r_gap && (sc % 3 == 1));
        m_rdata  = rd_base + 64'(r_beat);
        m_rlast  = r_act && (r_beat == rlast_at);
        m_awready = m_awvalid;
        tog = !tog;
        m_wready = w_tog ? tog : 1'b1;
        if (b_hs) m_bvalid = 1'b0;
        if (wl_hs) begin m_bvalid = 1'b1; m_bresp = bresp_cfg; end
      end
    end
  end

  // model: expectations derived from observed AXI handshakes and the requested block/address
  logic [BW-1:0] exp_rblk = '0, exp_wblk = '0;
  logic [AW-1:0] exp_rd_addr = '0, exp_wr_addr = '0;
  int m_rcnt = 0, m_widx = 0, rl_cnt = 0, br_cnt = 0;
  bit exp_rl = 1'b0, exp_br = 1'b0, exp_err = 1'b0, pv_ar = 1'b0, pv_aw = 1'b0, pv_w = 1'b0;

  initial begin : model
    forever begin
      @(negedge clk);
      if (!arstn) begin
        m_rcnt = 0; m_widx = 0; exp_rl = 1'b0; exp_br = 1'b0; exp_err = 1'b0;
        pv_ar = 1'b0; pv_aw = 1'b0; pv_w = 1'b0;
        continue;
      end
      chk("read_last", 512'(o_read_last), 512'(exp_rl));
      chk("b_resp", 512'(o_b_resp), 512'(exp_br));
      chk("bus_error", 512'(o_bus_error), 512'(exp_err));
      if (o_read_last) begin chk("rd_block", o_data_block, exp_rblk); rl_cnt++; end
      if (o_b_resp) br_cnt++;
      if (pv_ar) chk("arvalid_held", 512'(m_arvalid), 512'(1));
      if (pv_aw) chk("awvalid_held", 512'(m_awvalid), 512'(1));
      if (pv_w)  chk("wvalid_held", 512'(m_wvalid), 512'(1));
      if (m_arvalid) begin
        chk("araddr", 512'(m_araddr), 512'(exp_rd_addr));
        chk("arlen", 512'(m_arlen), 512'(7));
        chk("arsize", 512'(m_arsize), 512'(3));
        chk("arburst", 512'(m_arburst), 512'(1));
      end
      if (m_awvalid) begin
        chk("awaddr", 512'(m_awaddr), 512'(exp_wr_addr));
        chk("awlen", 512'(m_awlen), 512'(7));
        chk("awsize", 512'(m_awsize), 512'(3));
        chk("awburst", 512'(m_awburst), 512'(1));
      end
      if (m_wvalid && m_wready) begin
        chk("wdata", 512'(m_wdata), 512'(exp_wblk[m_widx*DW +: DW]));
        chk("wlast", 512'(m_wlast), 512'(m_widx == BEATS - 1));
        chk("wstrb", 512'(m_wstrb), 512'(8'hFF));
        m_widx++;
      end
      pv_ar = m_arvalid && !m_arready;
      pv_aw = m_awvalid && !m_awready;
      pv_w  = m_wvalid && !(m_wready && m_wlast);
      if (m_arvalid && m_arready) m_rcnt = 0;
      if (m_awvalid && m_awready) m_widx = 0;
      exp_rl = 1'b0;
      if (m_rvalid && m_rready) begin m_rcnt++; exp_rl = (m_rcnt == BEATS); end
      exp_br = m_bvalid && m_bready;
`ifdef AXI_RESP_CHECK_EN
      if ((m_rvalid && m_rready && m_rresp != 2'b00) || (m_bvalid && m_bready && m_bresp != 2'b00))
        exp_err = 1'b1;
`endif
    end
  end

  task automatic wait_pulse(input bit wr, input string name);
    int n;
    n = 0;
    while (!(wr ? o_b_resp : o_read_last) && n < 400) begin @(negedge clk); n++; end
    if (n >= 400) begin checks++; failures++; $display("FAIL %s timeout waiting for pulse", name); end
  endtask

  task automatic set_rd(input logic [DW-1:0] base);
    rd_base = base;
    for (int k = 0; k < BEATS; k++) exp_rblk[k*DW +: DW] = base + 64'(k);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n, arc, b0;
    logic [BW-1:0] blk;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_arvalid", 512'(m_arvalid), 512'(0));
    chk("rst_awvalid", 512'(m_awvalid), 512'(0));
    chk("rst_wvalid", 512'(m_wvalid), 512'(0));
    chk("rst_rready", 512'(m_rready), 512'(0));
    chk("rst_bready", 512'(m_bready), 512'(0));
    chk("rst_read_last", 512'(o_read_last), 512'(0));
    chk("rst_b_resp", 512'(o_b_resp), 512'(0));
    chk("rst_data_block", o_data_block, '0);
    chk("rst_bus_error", 512'(o_bus_error), 512'(0));
    arstn = 1'b1;
    @(posedge clk); #1;

    // T1: zero-wait read, rdata = beat index, pulse lands in cycle 11 (accept cycle = 1)
    i_addr = 64'h1234; exp_rd_addr = 64'h1200; set_rd(64'h0);
    i_start_read = 1'b1;
    n = 1;
    @(negedge clk);
    while (!o_read_last && n < 100) begin @(negedge clk); n++; end
    chk("t1_latency", 512'(n), 512'(11));
    chk("t1_word5", 512'(o_data_block[5*DW +: DW]), 512'(64'd5));
    chk("t1_word7", 512'(o_data_block[7*DW +: DW]), 512'(64'd7));
    i_start_read = 1'b0;
    @(negedge clk);
    chk("t1_pulse_width", 512'(o_read_last), 512'(0));

    // T2: write-back with wready toggling; block captured at accept
    @(posedge clk); #1;
    for (int k = 0; k < BEATS; k++) blk[k*DW +: DW] = 64'hA0 + 64'(k);
    i_data_block = blk; exp_wblk = blk;
    i_addr = 64'h403C; exp_wr_addr = 64'h4000; w_tog = 1'b1;
    b0 = br_cnt;
    i_start_write = 1'b1;
    @(posedge clk); #1;
    i_data_block = '1;
    wait_pulse(1'b1, "t2_b_resp");
    i_start_write = 1'b0;
    chk("t2_wbeats", 512'(m_widx), 512'(8));
    @(negedge clk);
    chk("t2_b_resp_once", 512'(br_cnt - b0), 512'(1));
    chk("t2_block_held", o_data_block, exp_rblk);
    w_tog = 1'b0;

    // T3: both requests high -> write-back first, then the refill from the next IDLE
    @(posedge clk); #1;
    for (int k = 0; k < BEATS; k++) blk[k*DW +: DW] = 64'h55 + 64'(k);
    i_data_block = blk; exp_wblk = blk;
    i_addr = 64'h8000_0040; exp_rd_addr = 64'h8000_0040; exp_wr_addr = 64'h8000_0040;
    set_rd(64'h1000);
    i_start_read = 1'b1; i_start_write = 1'b1;
    n = 0;
    while (!m_arvalid && !m_awvalid && n < 50) begin @(negedge clk); n++; end
    chk("t3_aw_first", 512'({m_awvalid, m_arvalid}), 512'(2'b10));
    wait_pulse(1'b1, "t3_b_resp");
    i_start_write = 1'b0;
    n = 0;
    while (!m_arvalid && n < 20) begin @(negedge clk); n++; end
    chk("t3_ar_after_b_resp", 512'(n), 512'(2));
    wait_pulse(1'b0, "t3_read_last");
    i_start_read = 1'b0;
    chk("t3_word3", 512'(o_data_block[3*DW +: DW]), 512'(64'h1003));

    // T4: slow arready, rvalid gaps, early rlast on beat 3
    @(posedge clk); #1;
    ar_delay = 5; r_gap = 1'b1; rlast_at = 3;
    i_addr = 64'h2_007F; exp_rd_addr = 64'h2_0040; set_rd(64'hDEAD_0000);
    i_start_read = 1'b1;
    n = 0; arc = 0;
    while (!o_read_last && n < 400) begin @(negedge clk); n++; if (m_arvalid) arc++; end
    i_start_read = 1'b0;
    chk("t4_ar_hold_cycles", 512'(arc), 512'(6));
    chk("t4_done", 512'(o_read_last), 512'(1));
    chk("t4_word6", 512'(o_data_block[6*DW +: DW]), 512'(64'hDEAD_0006));
    ar_delay = 0; r_gap = 1'b0; rlast_at = 7;

    // T5: reset in the middle of a refill, then a clean refill
    @(posedge clk); #1;
    i_addr = 64'h3000; exp_rd_addr = 64'h3000; set_rd(64'h7700);
    i_start_read = 1'b1;
    n = 0;
    while (m_rcnt < 4 && n < 100) begin @(negedge clk); n++; end
    @(posedge clk); #3;
    arstn = 1'b0;
    #1;
    chk("t5_rst_arvalid", 512'(m_arvalid), 512'(0));
    chk("t5_rst_rready", 512'(m_rready), 512'(0));
    chk("t5_rst_read_last", 512'(o_read_last), 512'(0));
    chk("t5_rst_block", o_data_block, '0);
    i_start_read = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    arstn = 1'b1;
    @(posedge clk); #1;
    set_rd(64'h9900);
    i_start_read = 1'b1;
    wait_pulse(1'b0, "t5_read_last");
    i_start_read = 1'b0;
    chk("t5_word7", 512'(o_data_block[7*DW +: DW]), 512'(64'h9907));

    // T6: SLVERR on BRESP
    @(posedge clk); #1;
    for (int k = 0; k < BEATS; k++) blk[k*DW +: DW] = 64'hC0 + 64'(k);
    i_data_block = blk; exp_wblk = blk;
    i_addr = 64'h5000; exp_wr_addr = 64'h5000; bresp_cfg = 2'b10;
    b0 = br_cnt;
    i_start_write = 1'b1;
    wait_pulse(1'b1, "t6_b_resp");
    i_start_write = 1'b0;
`ifdef AXI_RESP_CHECK_EN
    chk("t6_bus_error", 512'(o_bus_error), 512'(1));
`else
    chk("t6_bus_error", 512'(o_bus_error), 512'(0));
`endif
    @(negedge clk);
    chk("t6_b_resp_once", 512'(br_cnt - b0), 512'(1));
    bresp_cfg = 2'b00;

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
